pipeline_input_queue: RTL

- Upstream ingress buffer: one instance per pipeline, placed directly in front of pipeline_top's inputs/in_valid.
- Absorbs producer traffic while the pipeline is held by the global stall (shared-resource arbitration), so the producer sees valid/ready backpressure instead of lost data.
- Honours the per-pipeline flush by discarding all queued entries.

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/inq_storage.sv | 23 ++
 rtl/pipeline_input_queue.sv | 105 ++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, queue counter width helper, data word type.
package pipeline_pkg;

   localparam int unsigned DATA_W_DEFAULT    = 32;
   localparam int unsigned INQ_DEPTH_DEFAULT = 4;

   typedef logic [31:0] data_word_t;

   // Occupancy counter width able to hold 0..depth inclusive
   function automatic int unsigned inq_cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/inq_storage.sv
// Register-array storage for the pipeline input queue: one write port, async read port, no reset.
module inq_storage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [DATA_W-1:0]          wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [DATA_W-1:0]          rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port; contents are intentionally left unreset
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pipeline_input_queue.sv
// Ingress FIFO in front of a pipeline: absorbs producer traffic during stall, drops all on flush.
// Optional statistics outputs (stall_cycles, flush_drops) enabled by PIPELINE_INQ_STATS_EN.
module pipeline_input_queue
   import pipeline_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned DEPTH  = INQ_DEPTH_DEFAULT,
   parameter int unsigned CNT_W  = inq_cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic              stall,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic [CNT_W-1:0]  occupancy
`ifdef PIPELINE_INQ_STATS_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [15:0]       flush_drops
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic [CNT_W-1:0]  count, count_n;
   logic              push_c, pop_c;
   logic [DATA_W-1:0] head_c, out_data_n;

   assign push_c = in_valid & in_ready & ~flush;
   assign pop_c  = out_valid & ~stall & ~flush;

   inq_storage #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_storage (
      .clk   (clk),
      .we    (push_c),
      .waddr (wr_ptr),
      .wdata (in_data),
      .raddr (rd_ptr_n),
      .rdata (head_c)
   );

   // Next pointers/count; head word for the next cycle, taking a same-cycle write into account
   always_comb begin
      wr_ptr_n   = wr_ptr;
      rd_ptr_n   = rd_ptr;
      count_n    = count;
      out_data_n = '0;
      if (flush) begin
         count_n  = '0;
         rd_ptr_n = wr_ptr;
      end else begin
         if (push_c) wr_ptr_n = wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr_n = rd_ptr + PTR_W'(1);
         if (push_c && !pop_c)      count_n = count + CNT_W'(1);
         else if (!push_c && pop_c) count_n = count - CNT_W'(1);
      end
      // A write landing on the next head slot is only possible when it becomes the sole entry
      if (count_n != '0) out_data_n = (push_c && (wr_ptr == rd_ptr_n)) ? in_data : head_c;
   end

   // State and registered handshake/data outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         wr_ptr    <= wr_ptr_n;
         rd_ptr    <= rd_ptr_n;
         count     <= count_n;
         in_ready  <= (count_n != CNT_W'(DEPTH));
         out_valid <= (count_n != '0);
         out_data  <= out_data_n;
      end
   end

   assign occupancy = count;

`ifdef PIPELINE_INQ_STATS_EN
   logic [16:0] drops_sum_c;
   assign drops_sum_c = 17'(flush_drops) + 17'(count);

   // Saturating stall-cycle and flushed-entry counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_drops  <= '0;
      end else begin
         if (out_valid && stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
         if (flush) flush_drops <= drops_sum_c[16] ? 16'hFFFF : drops_sum_c[15:0];
      end
   end
`endif

endmodule
